// File: rtl/mips_bus_pkg.sv
//==============================================================================
// Module : mips_bus_pkg
// Brief  : Shared types and constants for the MIPS memory-mapped bus fabric.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mips_bus_state_t;

  localparam logic [31:0] MIPS_BUS_ERR_DATA = 32'hDEADBEEF;

  // Width of the slave index field; a single slave still needs one select bit.
  function automatic int mips_bus_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_bus_decoder.sv
//==============================================================================
// Module : mips_bus_decoder
// Brief  : Combinational address decoder: addr -> {mapped, index, one-hot sel}.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_bus_decoder
  import mips_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLAVE_LSB  = 12,
  parameter int SEL_W      = mips_bus_sel_w(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  mapped_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic [NUM_SLAVES-1:0] sel_o
);

  localparam int HI_LSB = SLAVE_LSB + SEL_W;

  logic w_upper_zero;

  assign idx_o = addr_i[SLAVE_LSB +: SEL_W];

  generate
    if (HI_LSB < ADDR_WIDTH) begin : g_hi
      assign w_upper_zero = (addr_i[ADDR_WIDTH-1:HI_LSB] == '0);
    end else begin : g_no_hi
      assign w_upper_zero = 1'b1;
    end
  endgenerate

  assign mapped_o = w_upper_zero && (32'(idx_o) < NUM_SLAVES);

  generate
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
      assign sel_o[i] = mapped_o && (32'(idx_o) == i);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mips_bus_fabric.sv
//==============================================================================
// Module : mips_bus_fabric
// Brief  : MIPS data-port interconnect with wait states, decode errors and a
//          timeout. Optional error capture when BUS_ERR_CAPTURE_EN is defined.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_bus_fabric
  import mips_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    SLAVE_LSB      = 12,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(MIPS_BUS_ERR_DATA)
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef BUS_ERR_CAPTURE_EN
  input  logic                             err_clr,
  output logic                             err_irq,
  output logic [ADDR_WIDTH-1:0]            err_addr,
`endif
  input  logic                             m_req,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic                             m_wr_en,
  input  logic [DATA_WIDTH-1:0]            m_wr_data,
  output logic [DATA_WIDTH-1:0]            m_rd_data,
  output logic                             m_ready,
  output logic                             m_err,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [SLAVE_LSB-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]            s_wr_data,
  output logic                             s_wr_en,
  output logic                             s_rd_en,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rd_data,
  input  logic [NUM_SLAVES-1:0]            s_ready
);

  localparam int SEL_W = mips_bus_sel_w(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef BUS_ERR_CAPTURE_EN
  localparam int ADDR_Q_W = ADDR_WIDTH;
`else
  localparam int ADDR_Q_W = SLAVE_LSB;
`endif

  mips_bus_state_t        state_q, state_d;
  logic [ADDR_Q_W-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   w_mapped;
  logic [SEL_W-1:0]       w_idx;
  logic [NUM_SLAVES-1:0]  w_sel;
  logic                   w_access;
  logic                   w_timeout;

  mips_bus_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_LSB  (SLAVE_LSB),
    .SEL_W      (SEL_W)
  ) u_decoder (
    .addr_i   (m_addr),
    .mapped_o (w_mapped),
    .idx_o    (w_idx),
    .sel_o    (w_sel)
  );

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          if (w_mapped) begin
            addr_d  = m_addr[ADDR_Q_W-1:0];
            wdata_d = m_wr_data;
            wr_d    = m_wr_en;
            sel_d   = w_sel;
            idx_d   = w_idx;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // A ready arriving on the timeout cycle still completes normally.
        if (s_ready[idx_q]) begin
          err_d   = 1'b0;
          rdata_d = wr_q ? '0 : s_rd_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
          state_d = RESP;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are gated by state so an async reset drops them immediately.
  assign w_access  = (state_q == ACCESS);
  assign m_ready   = (state_q == RESP);
  assign m_err     = m_ready & err_q;
  assign m_rd_data = m_ready ? rdata_q : '0;
  assign s_sel     = w_access ? sel_q : '0;
  assign s_addr    = w_access ? addr_q[SLAVE_LSB-1:0] : '0;
  assign s_wr_data = w_access ? wdata_q : '0;
  assign s_wr_en   = w_access & wr_q;
  assign s_rd_en   = w_access & ~wr_q;

`ifdef BUS_ERR_CAPTURE_EN
  logic                  err_irq_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic                  w_err_event;
  logic [ADDR_WIDTH-1:0] w_err_src;

  assign w_err_event = (state_d == RESP) && err_d;
  assign w_err_src   = (state_q == IDLE) ? m_addr : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
    end else if (err_clr) begin
      err_irq_q  <= 1'b0;
    end else if (w_err_event && !err_irq_q) begin
      err_irq_q  <= 1'b1;
      err_addr_q <= w_err_src;
    end
  end

  assign err_irq  = err_irq_q;
  assign err_addr = err_addr_q;
`endif

endmodule

`default_nettype wire
